// File: rtl/mpu_iic_pkg.sv
// Shared definitions for the MPU I2C target: FSM state encoding, the default device
// address, well-known MPU register addresses and the address-match helper.
package mpu_iic_pkg;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h68;

  localparam logic [7:0] PWR_MGMT_1   = 8'h6B;
  localparam logic [7:0] ACCEL_XOUT_H = 8'h3B;
  localparam logic [7:0] WHO_AM_I     = 8'h75;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAck,
    StReg,
    StWdata,
    StRdata,
    StAckM
  } iic_state_e;

  // True when the {addr, rw} byte targets this device.
  function automatic logic addr_match(input logic [7:0] addr_rw, input logic [6:0] dev);
    return addr_rw[7:1] == dev;
  endfunction

endpackage

// File: rtl/mpu_iic_if.sv
// Register-port bundle between the I2C target and a backing register file / sensor model.
//   reg_addr   current register pointer
//   reg_wdata  write byte, valid with reg_we
//   reg_we     1-cycle write strobe
//   reg_rdata  read data for reg_addr, valid 1 clk after reg_addr changes
// modport master: the I2C target side; modport slave: the register file side.
interface mpu_iic_if #(
  parameter int unsigned REG_AW = 8
) ();
  logic [REG_AW-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic [7:0]        reg_rdata;

  modport master (output reg_addr, output reg_wdata, output reg_we, input reg_rdata);
  modport slave  (input reg_addr, input reg_wdata, input reg_we, output reg_rdata);
endinterface

// File: rtl/iic_bus_cond.sv
// I2C bus conditioning: synchronises scl/sda_in and produces single-cycle event pulses.
//   clk, rst_n          system clock, asynchronous active-low reset
//   scl, sda_in         raw bus pins
//   sda_s               synchronised SDA level
//   scl_rise, scl_fall  edges of the synchronised SCL
//   start_det, stop_det SDA fall / rise while SCL is high
module iic_bus_cond #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_p_q;
  logic                   sda_ref_q;
  logic                   scl_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  assign scl_rise = scl_s & ~scl_p_q;
  assign scl_fall = ~scl_s & scl_p_q;

  // sda_ref_q is frozen on an SCL rise so an SDA edge landing in the same cycle is
  // still seen as START/STOP one cycle later, once SCL is known high.
  assign start_det = scl_s & scl_p_q & sda_ref_q & ~sda_s;
  assign stop_det  = scl_s & scl_p_q & ~sda_ref_q & sda_s;

  // Idle bus is high, so reset to 1 to avoid phantom edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_p_q    <= 1'b1;
      sda_ref_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_p_q    <= scl_s;
      if (!scl_rise) begin
        sda_ref_q <= sda_s;
      end
    end
  end

endmodule

// File: rtl/mpu_iic_target.sv
// I2C target emulating the MPU register interface.
//   clk, rst_n  system clock (>= 8x SCL), asynchronous active-low reset
//   scl, sda_in bus clock and pad-level data
//   sda_en      1 = pull SDA low (open drain)
//   busy        high from an addressed START until STOP
//   regs        register port (pointer, write data/strobe, read data)
module mpu_iic_target
  import mpu_iic_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = DEV_ADDR_DEFAULT,
  parameter int unsigned REG_AW      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      scl,
  input  logic      sda_in,
  output logic      sda_en,
  output logic      busy,
  mpu_iic_if.master regs
);

  localparam logic [REG_AW-1:0] AddrOne = {{(REG_AW-1){1'b0}}, 1'b1};

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  iic_bus_cond #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_bus_cond (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl       (scl),
    .sda_in    (sda_in),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  iic_state_e        state_q, after_ack_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic              phase_q;
  logic              sda_en_q, busy_q;
  logic [REG_AW-1:0] reg_addr_q;
  logic [7:0]        reg_wdata_q;
  logic              reg_we_q;
  logic [7:0]        rx_byte;

  assign rx_byte        = {shift_q[6:0], sda_s};
  assign sda_en         = sda_en_q;
  assign busy           = busy_q;
  assign regs.reg_addr  = reg_addr_q;
  assign regs.reg_wdata = reg_wdata_q;
  assign regs.reg_we    = reg_we_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      after_ack_q <= StReg;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      phase_q     <= 1'b0;
      sda_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= 8'h00;
      reg_we_q    <= 1'b0;
    end else begin
      reg_we_q <= 1'b0;
      // Post-write pointer increment lands one cycle after the strobe.
      if (reg_we_q) begin
        reg_addr_q <= reg_addr_q + AddrOne;
      end

      if (stop_det) begin
        state_q   <= StIdle;
        sda_en_q  <= 1'b0;
        busy_q    <= 1'b0;
        bit_cnt_q <= 3'd0;
        phase_q   <= 1'b0;
      end else if (start_det) begin
        state_q   <= StAddr;
        sda_en_q  <= 1'b0;
        bit_cnt_q <= 3'd0;
        phase_q   <= 1'b0;
      end else begin
        case (state_q)
          StAddr, StReg, StWdata: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                phase_q <= 1'b0;
                if (state_q == StAddr) begin
                  if (addr_match(rx_byte, DEV_ADDR)) begin
                    busy_q      <= 1'b1;
                    state_q     <= StAck;
                    after_ack_q <= rx_byte[0] ? StRdata : StReg;
                  end else begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                  end
                end else if (state_q == StReg) begin
                  reg_addr_q  <= REG_AW'(rx_byte);
                  state_q     <= StAck;
                  after_ack_q <= StWdata;
                end else begin
                  reg_wdata_q <= rx_byte;
                  reg_we_q    <= 1'b1;
                  state_q     <= StAck;
                  after_ack_q <= StWdata;
                end
              end
            end
          end

          // phase 0: waiting for the fall that starts the ACK bit; phase 1: ACK driven.
          StAck: begin
            if (scl_fall) begin
              if (!phase_q) begin
                sda_en_q <= 1'b1;
                phase_q  <= 1'b1;
              end else begin
                phase_q   <= 1'b0;
                bit_cnt_q <= 3'd0;
                state_q   <= after_ack_q;
                if (after_ack_q == StRdata) begin
                  shift_q  <= {regs.reg_rdata[6:0], 1'b0};
                  sda_en_q <= ~regs.reg_rdata[7];
                end else begin
                  sda_en_q <= 1'b0;
                end
              end
            end
          end

          // MSB is already on the bus; each fall presents the next bit.
          StRdata: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_q <= StAckM;
                phase_q <= 1'b0;
              end
            end
            if (scl_fall) begin
              sda_en_q <= ~shift_q[7];
              shift_q  <= {shift_q[6:0], 1'b0};
            end
          end

          // phase 0: release for the master ACK bit; phase 1: ACKed, reload on next fall.
          StAckM: begin
            if (scl_fall) begin
              if (!phase_q) begin
                sda_en_q <= 1'b0;
              end else begin
                phase_q   <= 1'b0;
                bit_cnt_q <= 3'd0;
                state_q   <= StRdata;
                shift_q   <= {regs.reg_rdata[6:0], 1'b0};
                sda_en_q  <= ~regs.reg_rdata[7];
              end
            end
            if (scl_rise) begin
              if (!sda_s) begin
                reg_addr_q <= reg_addr_q + AddrOne;
                phase_q    <= 1'b1;
              end else begin
                state_q <= StIdle;
              end
            end
          end

          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mpu_iic_target.sv
// Directed bench for mpu_iic_target: a bit-banged I2C master plus an 8-bit register
// file model with 1-clk read latency (reset contents regfile[i] = i).
module tb_mpu_iic_target;
  import mpu_iic_pkg::*;

  localparam int Q = 4;  // clocks per quarter SCL period

  logic clk = 1'b0;
  logic rst_n;
  logic scl_m, sda_m;
  logic sda_en, busy;
  wire  sda_bus = sda_m & ~sda_en;

  int checks = 0;
  int errors = 0;

  mpu_iic_if #(.REG_AW(8)) rif ();

  mpu_iic_target #(
    .DEV_ADDR    (7'h68),
    .REG_AW      (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .scl    (scl_m),
    .sda_in (sda_bus),
    .sda_en (sda_en),
    .busy   (busy),
    .regs   (rif)
  );

  always #5 clk = ~clk;

  logic [7:0] regfile [256];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) regfile[i] <= 8'(i);
    end else if (rif.reg_we) begin
      regfile[rif.reg_addr] <= rif.reg_wdata;
    end
  end
  always @(posedge clk) rif.reg_rdata <= regfile[rif.reg_addr];

  // Write log and SDA-drive counter, each owned by a single process.
  int         we_cnt = 0;
  int         en_cnt = 0;
  logic [7:0] wa [64];
  logic [7:0] wd [64];
  always @(posedge clk) begin
    if (rif.reg_we) begin
      wa[we_cnt] <= rif.reg_addr;
      wd[we_cnt] <= rif.reg_wdata;
      we_cnt     <= we_cnt + 1;
    end
    if (sda_en) en_cnt <= en_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    sda_m = 1'b0; wclk(Q);
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    sda_m = 1'b1; wclk(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wclk(Q);
    scl_m = 1'b1; wclk(2 * Q);
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    b = sda_bus;  wclk(Q);
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic a;
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(a);
    ack = ~a;
  endtask

  task automatic read_byte(output logic [7:0] b, input logic nack);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      read_bit(v);
      b[i] = v;
    end
    write_bit(nack);
  endtask

  logic       a0, a1, a2, a3, a4, a5;
  logic [7:0] rb;
  logic       bit_v;
  int         we_base, en_base;

  initial begin
    scl_m = 1'b1;
    sda_m = 1'b1;
    rst_n = 1'b0;
    wclk(3);
    check("reset_sda_en", 32'(sda_en), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_reg_addr", 32'(rif.reg_addr), 32'h0);
    check("reset_reg_we", 32'(rif.reg_we), 32'h0);
    check("reset_reg_wdata", 32'(rif.reg_wdata), 32'h0);
    rst_n = 1'b1;
    wclk(4);

    // 1: single register write PWR_MGMT_1 <= 0x00
    we_base = we_cnt;
    i2c_start();
    write_byte(8'hD0, a0);
    check("t1_busy_after_addr", 32'(busy), 32'h1);
    write_byte(PWR_MGMT_1, a1);
    write_byte(8'h00, a2);
    i2c_stop();
    wclk(4);
    check("t1_acks", {29'd0, a0, a1, a2}, 32'h7);
    check("t1_we_count", 32'(we_cnt - we_base), 32'h1);
    check("t1_we_addr", 32'(wa[we_base]), 32'h6B);
    check("t1_we_data", 32'(wd[we_base]), 32'h00);
    check("t1_busy_after_stop", 32'(busy), 32'h0);

    // 2: pointer write, repeated START, 14-byte read from ACCEL_XOUT_H
    i2c_start();
    write_byte(8'hD0, a0);
    write_byte(ACCEL_XOUT_H, a1);
    i2c_start();
    write_byte(8'hD1, a2);
    check("t2_acks", {29'd0, a0, a1, a2}, 32'h7);
    for (int i = 0; i < 14; i++) begin
      read_byte(rb, i == 13);
      check($sformatf("t2_read_%0d", i), 32'(rb), 32'h3B + 32'(i));
    end
    i2c_stop();
    wclk(4);
    check("t2_busy_after_stop", 32'(busy), 32'h0);

    // 3: wrong address is ignored
    we_base = we_cnt;
    en_base = en_cnt;
    i2c_start();
    write_byte(8'hD2, a0);
    check("t3_nack", 32'(a0), 32'h0);
    check("t3_busy", 32'(busy), 32'h0);
    i2c_stop();
    wclk(4);
    check("t3_no_drive", 32'(en_cnt - en_base), 32'h0);
    check("t3_no_we", 32'(we_cnt - we_base), 32'h0);

    // 4: burst write across the pointer wrap, then read back
    we_base = we_cnt;
    i2c_start();
    write_byte(8'hD0, a0);
    write_byte(8'hFE, a1);
    write_byte(8'h11, a2);
    write_byte(8'h22, a3);
    write_byte(8'h33, a4);
    write_byte(8'h44, a5);
    i2c_stop();
    wclk(4);
    check("t4_acks", {26'd0, a0, a1, a2, a3, a4, a5}, 32'h3F);
    check("t4_we_count", 32'(we_cnt - we_base), 32'h4);
    check("t4_addrs", {wa[we_base], wa[we_base+1], wa[we_base+2], wa[we_base+3]},
          32'hFEFF0001);
    check("t4_data", {wd[we_base], wd[we_base+1], wd[we_base+2], wd[we_base+3]},
          32'h11223344);
    i2c_start();
    write_byte(8'hD0, a0);
    write_byte(8'hFE, a1);
    i2c_start();
    write_byte(8'hD1, a2);
    for (int i = 0; i < 4; i++) begin
      read_byte(rb, i == 3);
      check($sformatf("t4_readback_%0d", i), 32'(rb), 32'h11 * 32'(i + 1));
    end
    i2c_stop();
    wclk(4);

    // 5: STOP after 4 data bits discards the byte; a following write is clean
    we_base = we_cnt;
    i2c_start();
    write_byte(8'hD0, a0);
    write_byte(PWR_MGMT_1, a1);
    write_bit(1'b1);
    write_bit(1'b0);
    write_bit(1'b1);
    write_bit(1'b0);
    i2c_stop();
    wclk(4);
    check("t5_partial_no_we", 32'(we_cnt - we_base), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    i2c_start();
    write_byte(8'hD0, a0);
    write_byte(PWR_MGMT_1, a1);
    write_byte(8'h5A, a2);
    i2c_stop();
    wclk(4);
    check("t5_acks", {29'd0, a0, a1, a2}, 32'h7);
    check("t5_we_count", 32'(we_cnt - we_base), 32'h1);
    check("t5_we_addr", 32'(wa[we_base]), 32'h6B);
    check("t5_we_data", 32'(wd[we_base]), 32'h5A);

    // 6: reset in the middle of a read byte (0x20 = 0010_0000)
    i2c_start();
    write_byte(8'hD0, a0);
    write_byte(8'h20, a1);
    i2c_start();
    write_byte(8'hD1, a2);
    read_bit(bit_v);
    read_bit(bit_v);
    read_bit(bit_v);
    check("t6_third_bit", 32'(bit_v), 32'h1);
    wclk(2);
    check("t6_driving_before_reset", 32'(sda_en), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_sda_released_in_reset", 32'(sda_en), 32'h0);
    check("t6_busy_in_reset", 32'(busy), 32'h0);
    sda_m = 1'b1;
    scl_m = 1'b1;
    wclk(4);
    rst_n = 1'b1;
    wclk(8);
    i2c_start();
    write_byte(8'hD0, a0);
    write_byte(8'h20, a1);
    i2c_start();
    write_byte(8'hD1, a2);
    check("t6_acks", {29'd0, a0, a1, a2}, 32'h7);
    read_byte(rb, 1'b0);
    check("t6_read_0", 32'(rb), 32'h20);
    read_byte(rb, 1'b1);
    check("t6_read_1", 32'(rb), 32'h21);
    i2c_stop();
    wclk(4);
    check("t6_busy_after_stop", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
